// File: rtl/csr_defines.sv
// Shared CSR definitions: addresses, TCFG fields, write bundle, timer FSM state.
// Used by csr_timer and csr_stable_counter.
package csr_defines;

    localparam int CSR_ADDR_W = 14;

    localparam logic [13:0] CSR_TID   = 14'h040;
    localparam logic [13:0] CSR_TCFG  = 14'h041;
    localparam logic [13:0] CSR_TVAL  = 14'h042;
    localparam logic [13:0] CSR_CNTC  = 14'h043;
    localparam logic [13:0] CSR_TICLR = 14'h044;

    localparam int TCFG_EN          = 0;
    localparam int TCFG_PERIODIC    = 1;
    localparam int TCFG_INITVAL_LSB = 2;
    localparam int TCFG_INITVAL_MSB = 31;

    localparam int TICLR_CLR = 0;

    typedef struct packed {
        logic                  we;
        logic [CSR_ADDR_W-1:0] addr;
        logic [31:0]           data;
    } csr_write_signal;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

    // TVAL load value is INITVAL shifted into place: {INITVAL, 2'b00}.
    function automatic logic [31:0] tcfg_load(input logic [31:0] cfg);
        return cfg & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/csr_stable_counter.sv
// Free-running 64-bit stable counter with optional CNTC compensation.
// Macro CSR_TIMER_CNTC_EN enables the writable CNTC register.
module csr_stable_counter
    import csr_defines::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cntc_we,
    input  logic [31:0] cntc_wdata,
    output logic [31:0] cntc,
    output logic [63:0] stable_cnt
);

    logic [63:0] raw_q;
    logic [63:0] raw_d;

    // Raw counter advances every cycle and wraps naturally.
    always_comb begin
        raw_d = raw_q + 64'd1;
    end

    // Raw counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            raw_q <= '0;
        end else begin
            raw_q <= raw_d;
        end
    end

`ifdef CSR_TIMER_CNTC_EN
    logic [31:0] cntc_q;
    logic [31:0] cntc_d;

    // CNTC takes the written value; otherwise holds.
    always_comb begin
        cntc_d = cntc_q;
        if (cntc_we) begin
            cntc_d = cntc_wdata;
        end
    end

    // CNTC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cntc_q <= '0;
        end else begin
            cntc_q <= cntc_d;
        end
    end

    assign cntc       = cntc_q;
    assign stable_cnt = raw_q + {{32{cntc_q[31]}}, cntc_q};
`else
    logic unused_cntc;
    assign unused_cntc = ^{cntc_we, cntc_wdata};

    assign cntc       = '0;
    assign stable_cnt = raw_q;
`endif

endmodule

// File: rtl/csr_timer.sv
// Timer CSR block: TID, TCFG, TVAL, TICLR, CNTC and the stable counter.
// Macro CSR_TIMER_CNTC_EN enables a writable CNTC offset.
module csr_timer
    import csr_defines::*;
#(
    parameter logic [31:0] CORE_ID = 32'd0
)(
    input  logic            clk,
    input  logic            rst,
    input  csr_write_signal csr_w,
    input  logic [13:0]     rd_addr,
    output logic [31:0]     rd_data,
    output logic            rd_hit,
    output logic            timer_int,
    output logic [63:0]     stable_cnt,
    output logic [31:0]     tid
);

    timer_state_t state_q, state_d;
    logic [31:0]  tid_q, tid_d;
    logic [31:0]  tcfg_q, tcfg_d;
    logic [31:0]  tval_q, tval_d;
    logic         int_q, int_d;
    logic [31:0]  cntc;

    logic         wr_tid;
    logic         wr_tcfg;
    logic         wr_ticlr;
    logic         wr_cntc;
    logic [31:0]  wr_load;
    logic [31:0]  reload;

    assign wr_tid   = csr_w.we && (csr_w.addr == CSR_TID);
    assign wr_tcfg  = csr_w.we && (csr_w.addr == CSR_TCFG);
    assign wr_ticlr = csr_w.we && (csr_w.addr == CSR_TICLR);
    assign wr_cntc  = csr_w.we && (csr_w.addr == CSR_CNTC);
    assign wr_load  = tcfg_load(csr_w.data);
    assign reload   = tcfg_load(tcfg_q);

    // Next-state: TCFG write overrides countdown; expiry set beats TICLR clear.
    always_comb begin
        state_d = state_q;
        tid_d   = tid_q;
        tcfg_d  = tcfg_q;
        tval_d  = tval_q;
        int_d   = int_q;
        if (wr_tid) begin
            tid_d = csr_w.data;
        end
        if (wr_ticlr && csr_w.data[TICLR_CLR]) begin
            int_d = 1'b0;
        end
        if (wr_tcfg) begin
            tcfg_d = csr_w.data;
            tval_d = wr_load;
            if (!csr_w.data[TCFG_EN]) begin
                state_d = OFF;
            end else if (wr_load != '0) begin
                state_d = RUN;
            end else begin
                state_d = DONE;
            end
        end else begin
            case (state_q)
                OFF: begin
                end
                RUN: begin
                    if (tval_q != '0) begin
                        tval_d = tval_q - 32'd1;
                        if (tval_q == 32'd1) begin
                            int_d = 1'b1;
                        end
                    end else if (tcfg_q[TCFG_PERIODIC] && (reload != '0)) begin
                        tval_d = reload;
                    end else begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    tval_d = '0;
                end
                default: begin
                    state_d = OFF;
                end
            endcase
        end
    end

    // Timer FSM and CSR registers, registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OFF;
            tid_q   <= CORE_ID;
            tcfg_q  <= '0;
            tval_q  <= '0;
            int_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tid_q   <= tid_d;
            tcfg_q  <= tcfg_d;
            tval_q  <= tval_d;
            int_q   <= int_d;
        end
    end

    csr_stable_counter u_stable_counter (
        .clk        (clk),
        .rst        (rst),
        .cntc_we    (wr_cntc),
        .cntc_wdata (csr_w.data),
        .cntc       (cntc),
        .stable_cnt (stable_cnt)
    );

    // Read mux shows pre-write register state, no bypass.
    always_comb begin
        rd_hit  = 1'b1;
        rd_data = '0;
        case (rd_addr)
            CSR_TID:   rd_data = tid_q;
            CSR_TCFG:  rd_data = tcfg_q;
            CSR_TVAL:  rd_data = tval_q;
            CSR_CNTC:  rd_data = cntc;
            CSR_TICLR: rd_data = '0;
            default:   rd_hit  = 1'b0;
        endcase
    end

    assign timer_int = int_q;
    assign tid       = tid_q;

endmodule

// File: tb/tb_csr_timer.sv
// Directed self-checking bench for csr_timer.
// Expected values are hand-derived from the timer behaviour.
module tb_csr_timer;
    import csr_defines::*;

    localparam logic [31:0] CID = 32'h0000_0007;

    logic            clk;
    logic            rst;
    csr_write_signal csr_w;
    logic [13:0]     rd_addr;
    logic [31:0]     rd_data;
    logic            rd_hit;
    logic            tmr_int;
    logic [63:0]     stable_cnt;
    logic [31:0]     tid;

    int checks = 0;
    int passes = 0;
    logic [63:0] m_raw;

    csr_timer #(.CORE_ID(CID)) dut (
        .clk        (clk),
        .rst        (rst),
        .csr_w      (csr_w),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_hit     (rd_hit),
        .timer_int  (tmr_int),
        .stable_cnt (stable_cnt),
        .tid        (tid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) m_raw <= '0;
        else     m_raw <= m_raw + 64'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d);
        csr_w.we   = 1'b1;
        csr_w.addr = a;
        csr_w.data = d;
        @(posedge clk);
        #1;
        csr_w.we = 1'b0;
    endtask

    task automatic rd(input logic [13:0] a, output logic [31:0] d);
        rd_addr = a;
        #1;
        d = rd_data;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b1;
        csr_w = '0;
        rd_addr = '0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (tid !== CID) $display("FAIL reset_tid got %h want %h", tid, CID);
        else passes++;
        checks++;
        if (stable_cnt !== 64'd0) $display("FAIL reset_cnt got %h want 0", stable_cnt);
        else passes++;
        checks++;
        if (tmr_int !== 1'b0) $display("FAIL reset_int got %b want 0", tmr_int);
        else passes++;
        rd(CSR_TCFG, v);
        checks++;
        if (v !== 32'd0) $display("FAIL reset_tcfg got %h want 0", v);
        else passes++;
        rd(CSR_TVAL, v);
        checks++;
        if (v !== 32'd0) $display("FAIL reset_tval got %h want 0", v);
        else passes++;
        rd(CSR_TID, v);
        checks++;
        if (v !== CID || rd_hit !== 1'b1)
            $display("FAIL reset_rd_tid got %h/%b want %h/1", v, rd_hit, CID);
        else passes++;
        rd(14'h045, v);
        checks++;
        if (v !== 32'd0 || rd_hit !== 1'b0)
            $display("FAIL miss_addr got %h/%b want 0/0", v, rd_hit);
        else passes++;
    endtask

    task automatic test_tid();
        csr_w.we   = 1'b1;
        csr_w.addr = CSR_TID;
        csr_w.data = 32'hDEAD_BEEF;
        rd_addr    = CSR_TID;
        #1;
        checks++;
        if (rd_data !== CID) $display("FAIL tid_no_bypass got %h want %h", rd_data, CID);
        else passes++;
        @(posedge clk);
        #1;
        csr_w.we = 1'b0;
        checks++;
        if (tid !== 32'hDEAD_BEEF) $display("FAIL tid_write got %h want deadbeef", tid);
        else passes++;
        csr_w.data = 32'h1234_5678;
        tick();
        checks++;
        if (tid !== 32'hDEAD_BEEF) $display("FAIL tid_no_we got %h want deadbeef", tid);
        else passes++;
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        wr(CSR_TCFG, 32'h0000_0011);
        rd(CSR_TVAL, v);
        checks++;
        if (v !== 32'd16) $display("FAIL os_load got %0d want 16", v);
        else passes++;
        for (int k = 1; k <= 16; k++) begin
            tick();
            rd(CSR_TVAL, v);
            checks++;
            if (v !== 32'(16 - k) || tmr_int !== 1'(k == 16))
                $display("FAIL os_cnt%0d got %0d/%b want %0d/%b", k, v, tmr_int, 16 - k, k == 16);
            else passes++;
        end
        repeat (3) tick();
        rd(CSR_TVAL, v);
        checks++;
        if (v !== 32'd0 || tmr_int !== 1'b1)
            $display("FAIL os_hold got %0d/%b want 0/1", v, tmr_int);
        else passes++;
        wr(CSR_TICLR, 32'd1);
        checks++;
        if (tmr_int !== 1'b0) $display("FAIL os_clr got %b want 0", tmr_int);
        else passes++;
        repeat (20) tick();
        rd(CSR_TVAL, v);
        checks++;
        if (v !== 32'd0 || tmr_int !== 1'b0)
            $display("FAIL os_done got %0d/%b want 0/0", v, tmr_int);
        else passes++;
        rd(CSR_TCFG, v);
        checks++;
        if (v !== 32'h11) $display("FAIL os_tcfg got %h want 11", v);
        else passes++;
    endtask

    task automatic test_periodic();
        logic [31:0] v;
        wr(CSR_TCFG, 32'h0000_000B);
        rd(CSR_TVAL, v);
        checks++;
        if (v !== 32'd8) $display("FAIL per_load got %0d want 8", v);
        else passes++;
        for (int k = 1; k <= 8; k++) begin
            tick();
            rd(CSR_TVAL, v);
            checks++;
            if (v !== 32'(8 - k) || tmr_int !== 1'(k == 8))
                $display("FAIL per_a%0d got %0d/%b want %0d/%b", k, v, tmr_int, 8 - k, k == 8);
            else passes++;
        end
        wr(CSR_TICLR, 32'd1);
        rd(CSR_TVAL, v);
        checks++;
        if (v !== 32'd8 || tmr_int !== 1'b0)
            $display("FAIL per_reload got %0d/%b want 8/0", v, tmr_int);
        else passes++;
        for (int k = 10; k <= 17; k++) begin
            tick();
            rd(CSR_TVAL, v);
            checks++;
            if (v !== 32'(17 - k) || tmr_int !== 1'(k == 17))
                $display("FAIL per_b%0d got %0d/%b want %0d/%b", k, v, tmr_int, 17 - k, k == 17);
            else passes++;
        end
    endtask

    task automatic test_ticlr_collision();
        logic [31:0] v;
        wr(CSR_TCFG, 32'h0000_000B);
        checks++;
        if (tmr_int !== 1'b1) $display("FAIL col_tcfg_keeps_int got %b want 1", tmr_int);
        else passes++;
        wr(CSR_TICLR, 32'd1);
        rd(CSR_TVAL, v);
        checks++;
        if (v !== 32'd7 || tmr_int !== 1'b0)
            $display("FAIL col_pre got %0d/%b want 7/0", v, tmr_int);
        else passes++;
        repeat (6) tick();
        rd(CSR_TVAL, v);
        checks++;
        if (v !== 32'd1 || tmr_int !== 1'b0)
            $display("FAIL col_at1 got %0d/%b want 1/0", v, tmr_int);
        else passes++;
        wr(CSR_TICLR, 32'd1);
        rd(CSR_TVAL, v);
        checks++;
        if (v !== 32'd0 || tmr_int !== 1'b1)
            $display("FAIL col_set_wins got %0d/%b want 0/1", v, tmr_int);
        else passes++;
        wr(CSR_TICLR, 32'd1);
        rd(CSR_TVAL, v);
        checks++;
        if (v !== 32'd8 || tmr_int !== 1'b0)
            $display("FAIL col_clear got %0d/%b want 8/0", v, tmr_int);
        else passes++;
    endtask

    task automatic test_disable();
        logic [31:0] v;
        wr(CSR_TCFG, 32'h0000_0011);
        repeat (11) tick();
        rd(CSR_TVAL, v);
        checks++;
        if (v !== 32'd5) $display("FAIL dis_at5 got %0d want 5", v);
        else passes++;
        wr(CSR_TCFG, 32'h0000_0014);
        rd(CSR_TVAL, v);
        checks++;
        if (v !== 32'd20) $display("FAIL dis_load got %0d want 20", v);
        else passes++;
        repeat (10) tick();
        rd(CSR_TVAL, v);
        checks++;
        if (v !== 32'd20 || tmr_int !== 1'b0)
            $display("FAIL dis_hold got %0d/%b want 20/0", v, tmr_int);
        else passes++;
        wr(CSR_TVAL, 32'h0000_1234);
        rd(CSR_TVAL, v);
        checks++;
        if (v !== 32'd20) $display("FAIL tval_ro got %0d want 20", v);
        else passes++;
        wr(CSR_TICLR, 32'hFFFF_FFFE);
        rd(CSR_TICLR, v);
        checks++;
        if (v !== 32'd0 || rd_hit !== 1'b1)
            $display("FAIL ticlr_rd got %h/%b want 0/1", v, rd_hit);
        else passes++;
        rd(CSR_TCFG, v);
        checks++;
        if (v !== 32'h14) $display("FAIL dis_tcfg got %h want 14", v);
        else passes++;
    endtask

    task automatic test_cntc();
        logic [31:0] v;
        logic [63:0] exp_cnt;
        logic [31:0] exp_cntc;
        wr(CSR_CNTC, 32'hFFFF_FFFF);
`ifdef CSR_TIMER_CNTC_EN
        exp_cnt  = m_raw - 64'd1;
        exp_cntc = 32'hFFFF_FFFF;
`else
        exp_cnt  = m_raw;
        exp_cntc = 32'd0;
`endif
        checks++;
        if (stable_cnt !== exp_cnt)
            $display("FAIL cntc_stable got %h want %h", stable_cnt, exp_cnt);
        else passes++;
        rd(CSR_CNTC, v);
        checks++;
        if (v !== exp_cntc || rd_hit !== 1'b1)
            $display("FAIL cntc_rd got %h/%b want %h/1", v, rd_hit, exp_cntc);
        else passes++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        wr(CSR_TCFG, 32'h0000_0011);
        repeat (13) tick();
        rd(CSR_TVAL, v);
        checks++;
        if (v !== 32'd3) $display("FAIL rm_at3 got %0d want 3", v);
        else passes++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd(CSR_TVAL, v);
        checks++;
        if (v !== 32'd0 || tmr_int !== 1'b0)
            $display("FAIL rm_state got %0d/%b want 0/0", v, tmr_int);
        else passes++;
        checks++;
        if (tid !== CID || stable_cnt !== 64'd0)
            $display("FAIL rm_tid_cnt got %h/%h want %h/0", tid, stable_cnt, CID);
        else passes++;
        repeat (5) tick();
        rd(CSR_TVAL, v);
        checks++;
        if (v !== 32'd0 || tmr_int !== 1'b0 || stable_cnt !== 64'd5)
            $display("FAIL rm_after got %0d/%b/%0d want 0/0/5", v, tmr_int, stable_cnt);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_tid();
        test_oneshot();
        test_periodic();
        test_ticlr_collision();
        test_disable();
        test_cntc();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/csr_timer.md
CSR_TIMER -- requirements
Module: csr_timer

Interface
REQ-001 Parameter CORE_ID, default 0, reset value of TID.
REQ-002 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: csr_w  in  csr_write_signal (we, addr[13:0], data[31:0])  committed CSR write from the CSR write stage.
REQ-005 Port: rd_addr  in  14  CSR read address.
REQ-006 Port: rd_data  out  32  combinational read data for timer CSRs; 0 for other addresses.
REQ-007 Port: rd_hit  out  1  high when rd_addr is TID, TCFG, TVAL, CNTC or TICLR.
REQ-008 Port: timer_int  out  1  registered timer interrupt pending (drives ESTAT.IS[11]).
REQ-009 Port: stable_cnt  out  64  stable counter value for rdcnt instructions.
REQ-010 Port: tid  out  32  current TID register.

Function
REQ-011 A write acts only when csr_w.we=1; addr selects the register; unlisted addresses are ignored.
REQ-012 TID write stores data[31:0]; takes effect the next cycle.
REQ-013 TCFG write stores EN, PERIODIC and INITVAL, and loads TVAL with {INITVAL,2'b00} in the same edge.
REQ-014 TVAL, and TICLR bits other than CLR, are read-only; writes are ignored; TICLR reads 0.
REQ-015 FSM states: OFF, RUN, DONE; reset state OFF.
REQ-016 OFF: TVAL holds; a TCFG write with EN=1 and nonzero load value goes to RUN; EN=1 with zero load value goes to DONE.
REQ-017 RUN: TVAL decrements by 1 per cycle.
REQ-018 RUN with TVAL=1: next TVAL=0 and timer_int sets on that edge.
REQ-019 RUN with TVAL=0: PERIODIC=1 and INITVAL!=0 reloads {INITVAL,2'b00} and stays RUN; otherwise goes to DONE.
REQ-020 DONE: TVAL holds 0 and no further interrupts fire.
REQ-021 A TCFG write in any state overrides the decrement/reload of that cycle and re-evaluates per REQ-016; EN=0 goes to OFF.
REQ-022 A TICLR write with data[0]=1 clears timer_int on the next edge.
REQ-023 Simultaneous expiry (REQ-018) and TICLR clear: set wins, timer_int=1.
REQ-024 The raw 64-bit stable counter increments by 1 every cycle and wraps 2^64-1 -> 0.
REQ-025 rd_data returns register state before the current-cycle write, with no bypass.

Reset
REQ-026 On rst: TID=CORE_ID, TCFG=0, TVAL=0, FSM=OFF, timer_int=0, raw counter=0, CNTC=0.
REQ-027 Reset asserted mid-count aborts the count immediately; a pending interrupt is lost.

Configuration
REQ-028 Macro CSR_TIMER_CNTC_EN: defined gives a writable CNTC, and stable_cnt = raw + sign-extended CNTC (mod 2^64).
REQ-029 Without CSR_TIMER_CNTC_EN: CNTC writes are ignored, CNTC reads 0, and stable_cnt = raw.

Structure
REQ-030 CSR addresses, TCFG field ranges and csr_write_signal are taken from the shared csr_defines package.
REQ-031 The FSM state enum (OFF/RUN/DONE) is added to csr_defines as timer_state_t.
REQ-032 One sub-module, csr_stable_counter, holds the raw counter and the CNTC compensation, including the REQ-028/029 gating.

Verification
REQ-033 Write TCFG=0x0000_0011 (INITVAL=4, EN=1, one-shot) -> TVAL reads 16, 15, ...; timer_int=1 on the 16th edge after the write; FSM goes to DONE; TVAL stays 0.
REQ-034 Write TCFG=0x0000_000B (INITVAL=2, periodic) -> interrupt after 8 cycles, TVAL reloads 8, interrupt recurs every 9 cycles.
REQ-035 Expiry cycle coincides with TICLR=1 -> timer_int stays 1; a later TICLR=1 alone -> 0 next cycle.
REQ-036 TCFG write with EN=0 mid-count at TVAL=5 -> TVAL loads the new value and holds; FSM=OFF; no interrupt.
REQ-037 CNTC=0xFFFF_FFFF with macro defined -> stable_cnt = raw-1; without the macro -> stable_cnt = raw and CNTC reads 0.
REQ-038 rst pulse at TVAL=3 -> the next cycle shows TVAL=0, timer_int=0, TID=CORE_ID, stable_cnt=0.
